// File: rtl/emergency_preempt.sv
// Siren/transponder qualifier: synchronizes, debounces, holds and cools down the emergency level.
// Optional operator override enabled by defining EMERGENCY_MANUAL_EN.
module emergency_preempt #(
    parameter int DEBOUNCE   = 4,
    parameter int HOLD       = 8,
    parameter int MAX_ACTIVE = 32,
    parameter int COOLDOWN   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       siren_raw,
    input  logic       manual_req,
    output logic       emergency,
    output logic       busy,
    output logic       timeout,
    output logic [7:0] event_count
);

    // state    | meaning
    // IDLE     | waiting for synchronized sensor high
    // QUAL     | debouncing, sensor must stay high
    // ACTIVE   | emergency asserted, held for HOLD..MAX_ACTIVE cycles
    // COOL     | forced-low window, sensor ignored
    typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, COOL} state_t;

    localparam logic [5:0] DEB_LAST  = 6'(DEBOUNCE - 1);
    localparam logic [5:0] HOLD_LAST = 6'(HOLD - 1);
    localparam logic [5:0] MAX_LAST  = 6'(MAX_ACTIVE - 1);
    localparam logic [5:0] COOL_LAST = 6'(COOLDOWN - 1);

    state_t     state;
    state_t     state_nxt;
    logic       s1;
    logic       s;
    logic [5:0] cnt;
    logic       timeout_hit;
    logic       manual_go;
    logic       emergency_d;
    logic       busy_d;
    logic       entering;

`ifdef EMERGENCY_MANUAL_EN
    assign manual_go = manual_req;
`else
    logic unused_manual;
    assign unused_manual = manual_req;
    assign manual_go     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1          <= 1'b0;
            s           <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            emergency   <= 1'b0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
            event_count <= '0;
        end else begin
            s1        <= siren_raw;
            s         <= s1;
            state     <= state_nxt;
            emergency <= emergency_d;
            busy      <= busy_d;
            if (state_nxt != state || state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 6'd1;
            if (timeout_hit)
                timeout <= 1'b1;
            if (entering && event_count != 8'hFF)
                event_count <= event_count + 8'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (manual_go)
                    state_nxt = ACTIVE;
                else if (s)
                    state_nxt = QUAL;
            end
            QUAL: begin
                if (manual_go)
                    state_nxt = ACTIVE;
                else if (!s)
                    state_nxt = IDLE;
                else if (cnt == DEB_LAST)
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                // a stuck sensor is cut off even if it happens to release on the same cycle
                if (cnt == MAX_LAST) begin
                    state_nxt   = COOL;
                    timeout_hit = 1'b1;
                end else if (cnt >= HOLD_LAST && !s) begin
                    state_nxt = COOL;
                end
            end
            COOL: begin
                if (cnt == COOL_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        emergency_d = (state_nxt == ACTIVE);
        busy_d      = (state_nxt != IDLE);
        entering    = (state_nxt == ACTIVE) && (state != ACTIVE);
    end

endmodule

// File: tb/tb_emergency_preempt.sv
// Scoreboard bench for emergency_preempt: per-cycle expected emergency/busy derived from the timing rules.
module tb_emergency_preempt;

    localparam int D  = 4;
    localparam int HO = 8;
    localparam int MX = 32;
    localparam int CD = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       siren_raw = 1'b0;
    logic       manual_req = 1'b0;
    logic       emergency;
    logic       busy;
    logic       timeout;
    logic [7:0] event_count;

    int checks = 0;
    int errors = 0;
    int exp_count;
    bit exp_timeout;

    logic [1:0] sb_q[$];
    bit sir_pat[0:127];
    bit man_pat[0:127];
    bit em_pat[0:127];
    bit busy_pat[0:127];

    emergency_preempt dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .siren_raw   (siren_raw),
        .manual_req  (manual_req),
        .emergency   (emergency),
        .busy        (busy),
        .timeout     (timeout),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 128; i++) begin
            sir_pat[i]  = 1'b0;
            man_pat[i]  = 1'b0;
            em_pat[i]   = 1'b0;
            busy_pat[i] = 1'b0;
        end
    endtask

    task automatic set_sir(input int lo, input int hi);
        for (int i = lo; i < hi; i++) sir_pat[i] = 1'b1;
    endtask

    task automatic set_em(input int lo, input int hi);
        for (int i = lo; i < hi; i++) em_pat[i] = 1'b1;
    endtask

    task automatic set_busy(input int lo, input int hi);
        for (int i = lo; i < hi; i++) busy_pat[i] = 1'b1;
    endtask

    // Cycle k: input applied before edge Ek, outputs observed just after Ek.
    task automatic plan_pulse(input int h);
        int a;
        int ex;
        clear_plan();
        set_sir(0, h);
        if (h >= D + 1) begin
            a  = 2 + D;
            ex = (a + HO > h + 2) ? a + HO : h + 2;
            set_em(a, ex);
            set_busy(2, ex + CD);
            exp_count++;
        end else if (h >= 1) begin
            set_busy(2, h + 2);
        end
    endtask

    task automatic run_plan(input int n, input string tag);
        logic [1:0] e;
        for (int k = 0; k < n; k++) begin
            siren_raw  = sir_pat[k];
            manual_req = man_pat[k];
            sb_q.push_back({em_pat[k], busy_pat[k]});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check($sformatf("%s_em_c%0d", tag, k), 32'(emergency), 32'(e[1]));
            check($sformatf("%s_busy_c%0d", tag, k), 32'(busy), 32'(e[0]));
        end
        siren_raw  = 1'b0;
        manual_req = 1'b0;
        check({tag, "_count"}, 32'(event_count), 32'(exp_count));
        check({tag, "_timeout"}, 32'(timeout), 32'(exp_timeout));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        siren_raw  = 1'b0;
        manual_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_em", 32'(emergency), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_count", 32'(event_count), 32'd0);
        rst_n       = 1'b1;
        exp_count   = 0;
        exp_timeout = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        int a1, f1, i1, a2, f2, i2;

        // reset then quiet sensor
        do_reset();
        clear_plan();
        run_plan(20, "idle");

        // clean 10-cycle event: emergency from E6 for exactly HOLD cycles
        do_reset();
        plan_pulse(10);
        run_plan(30, "clean");

        // sensor held past HOLD extends the event
        do_reset();
        plan_pulse(15);
        run_plan(30, "extend");

        // glitch dropping during debounce
        do_reset();
        plan_pulse(3);
        run_plan(12, "glitch");

        // stuck sensor: timeout, cooldown, requalify
        do_reset();
        clear_plan();
        set_sir(0, 60);
        a1 = 2 + D;
        f1 = a1 + MX;
        i1 = f1 + CD;
        a2 = i1 + 1 + D;
        f2 = (a2 + HO > 62) ? a2 + HO : 62;
        i2 = f2 + CD;
        set_em(a1, f1);
        set_em(a2, f2);
        set_busy(2, i1);
        set_busy(i1 + 1, i2);
        exp_count   = 2;
        exp_timeout = 1'b1;
        run_plan(80, "stuck");

`ifdef EMERGENCY_MANUAL_EN
        // operator pulse in IDLE, second pulse during COOLDOWN must be ignored
        do_reset();
        clear_plan();
        man_pat[3]  = 1'b1;
        man_pat[13] = 1'b1;
        set_em(3, 3 + HO);
        set_busy(3, 3 + HO + CD);
        exp_count = 1;
        run_plan(25, "manual");
`endif

        // reset on the 4th ACTIVE cycle
        do_reset();
        siren_raw = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check("midrst_pre_em", 32'(emergency), 32'd1);
        check("midrst_pre_count", 32'(event_count), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_em", 32'(emergency), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(event_count), 32'd0);
        rst_n     = 1'b1;
        siren_raw = 1'b0;

        // 256 back-to-back short events saturate the counter
        do_reset();
        for (int ev = 0; ev < 256; ev++) begin
            siren_raw = 1'b1;
            repeat (D + 1) @(posedge clk);
            #1;
            siren_raw = 1'b0;
            repeat (16) @(posedge clk);
            #1;
            if (exp_count < 255) exp_count++;
            if (ev == 0 || ev == 254 || ev == 255)
                check($sformatf("sat_count_ev%0d", ev), 32'(event_count), 32'(exp_count));
        end
        check("sat_timeout", 32'(timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
